// File: rtl/myproject_dense_pkg.sv
// Shared types, default widths and width-rule helper for the dense-layer accumulator.
package myproject_dense_pkg;

    typedef enum logic {
        S_ACC,
        S_OUT
    } dense_acc_state_t;

    localparam int PROD_WIDTH_D = 12;
    localparam int ACC_WIDTH_D  = 18;
    localparam int OUT_WIDTH_D  = 16;

    // Smallest accumulator that can sum n_in products without wrapping, plus the guard bit.
    function automatic int min_acc_width(input int prod_width, input int n_in);
        return prod_width + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/myproject_dense_acc_if.sv
// Product-in / result-out handshake bundle of the dense accumulator.
interface myproject_dense_acc_if
    import myproject_dense_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_D,
    parameter int OUT_WIDTH  = OUT_WIDTH_D
);
    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         prod_valid;
    logic                         prod_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         ovf_sticky;

    modport master (
        output prod_data, prod_valid, out_ready,
        input  prod_ready, out_data, out_valid, ovf_sticky
    );

    modport slave (
        input  prod_data, prod_valid, out_ready,
        output prod_ready, out_data, out_valid, ovf_sticky
    );
endinterface

// File: rtl/myproject_shift_sat.sv
// Combinational arithmetic shift, optional ReLU and signed saturation to OUT_WIDTH.
// ReLU is compiled in when MYPROJECT_DENSE_ACC_RELU_EN is defined.
module myproject_shift_sat #(
    parameter int ACC_WIDTH = 18,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic signed [ACC_WIDTH-1:0] din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        clipped
);

    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [ACC_WIDTH-1:0]   rect;
    logic [ACC_WIDTH-OUT_WIDTH:0]  top;

    always_comb begin
        shifted = din >>> SHIFT;
`ifdef MYPROJECT_DENSE_ACC_RELU_EN
        rect = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
        rect = shifted;
`endif
        // Value fits iff every bit above the output sign bit equals it.
        top     = rect[ACC_WIDTH-1:OUT_WIDTH-1];
        clipped = !((&top) || !(|top));
        if (!clipped) begin
            dout = rect[OUT_WIDTH-1:0];
        end else if (rect[ACC_WIDTH-1]) begin
            dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/myproject_dense_acc.sv
// Streaming neuron accumulator: sums N_IN products onto BIAS, then shift/ReLU/saturate.
// Optional ReLU via MYPROJECT_DENSE_ACC_RELU_EN.
module myproject_dense_acc
    import myproject_dense_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_D,
    parameter int N_IN       = 16,
    parameter int ACC_WIDTH  = ACC_WIDTH_D,
    parameter int OUT_WIDTH  = OUT_WIDTH_D,
    parameter int SHIFT      = 0,
    parameter logic signed [ACC_WIDTH-1:0] BIAS = '0
) (
    input logic                ap_clk,
    input logic                ap_rst_n,
    myproject_dense_acc_if.slave bus
);

    localparam int              CNT_W    = $clog2(N_IN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    if (N_IN < 2 || ACC_WIDTH < min_acc_width(PROD_WIDTH, N_IN) ||
        OUT_WIDTH > ACC_WIDTH || SHIFT < 0 || SHIFT >= ACC_WIDTH) begin : g_bad_params
        $error("myproject_dense_acc: illegal parameter combination");
    end

    dense_acc_state_t            state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]            cnt;
    logic signed [OUT_WIDTH-1:0] res;
    logic                        res_clip;
    logic                        prod_ready;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        ovf_sticky;

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
    assign acc_next = acc + prod_ext;

    myproject_shift_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_shift_sat (
        .din     (acc_next),
        .dout    (res),
        .clipped (res_clip)
    );

    // prod_ready/out_valid are registered copies of the state so nothing downstream
    // sees a combinational path through this block.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= S_ACC;
            acc        <= BIAS;
            cnt        <= '0;
            prod_ready <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            unique case (state)
                S_ACC: begin
                    prod_ready <= 1'b1;
                    if (bus.prod_valid && prod_ready) begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            out_data   <= res;
                            ovf_sticky <= ovf_sticky | res_clip;
                            out_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                            state      <= S_OUT;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_valid && bus.out_ready) begin
                        acc        <= BIAS;
                        out_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                        state      <= S_ACC;
                    end
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.ovf_sticky = ovf_sticky;

endmodule
